// File: rtl/video_dma_pkg.sv
// Shared types and constants for the video DMA read engine.
package video_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_FILL_CHECK,
    ST_WRITE,
    ST_IRQ
  } state_t;

  // Bit positions inside the control register.
  localparam int CTR_START = 0;
  localparam int CTR_ABORT = 1;

  // Every bus read fetches a full 32-bit word.
  localparam logic [3:0] WB_SEL = 4'hF;

endpackage

// File: rtl/video_dma_pack_buf.sv
// Pack staging buffer: one 32-bit word written as four bytes (MSB first at the
// lowest index), read back one byte at a time. Holds data only, so no reset.
module video_dma_pack_buf #(
  parameter int NBPACK = 16,
  parameter int IDX_W  = $clog2(NBPACK)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem_q [NBPACK];
  logic [7:0] mem_d [NBPACK];

  // Scatter the incoming word into four consecutive byte slots.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx]              = wr_data[31:24];
      mem_d[wr_idx + IDX_W'(1)]  = wr_data[23:16];
      mem_d[wr_idx + IDX_W'(2)]  = wr_data[15:8];
      mem_d[wr_idx + IDX_W'(3)]  = wr_data[7:0];
    end
  end

  // Byte storage register.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/video_dma_read.sv
// Video DMA read engine: fetches a frame over Wishbone in packs of NBPACK
// bytes and streams the bytes into a FIFO, pulsing an interrupt at frame end.
// Optional build macro VIDEO_DMA_READ_CONTINUOUS_EN: loop over the frame
// forever (from the latched base) until aborted.
module video_dma_read
  import video_dma_pkg::*;
#(
  parameter int P_WIDTH    = 640,
  parameter int P_HEIGHT   = 480,
  parameter int NBPACK     = 16,
  parameter int INT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] wb_reg_data,
  input  logic [31:0] wb_reg_ctr,
  output logic        interrupt,
  output logic        busy,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [31:0] p_wb_ADR_O,
  input  logic        full,
  output logic        w_e,
  output logic [7:0]  pixel_out
);

  localparam int TOTAL  = P_WIDTH * P_HEIGHT;
  localparam int PIX_W  = $clog2(TOTAL + 1);
  localparam int PACK_W = $clog2(NBPACK + 1);
  localparam int IDX_W  = $clog2(NBPACK);

  localparam logic [PIX_W-1:0]  TOTAL_C    = PIX_W'(TOTAL);
  localparam logic [PIX_W-1:0]  NBPACK_PIX = PIX_W'(NBPACK);
  localparam logic [PACK_W-1:0] NBPACK_C   = PACK_W'(NBPACK);
  localparam logic [PACK_W-1:0] LAST_C     = PACK_W'(NBPACK - 1);
  localparam logic [3:0]        INT_LAST   = 4'(INT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [29:0]         base_q, base_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [PACK_W-1:0]   pack_q, pack_d;
  logic [3:0]          irq_cnt_q, irq_cnt_d;
  logic                start_prev_q, start_prev_d;

  logic                start_edge;
  logic                abort;
  logic                rd_ack;
  logic                wr_fire;
  logic                last_write;
  logic [PIX_W-1:0]    pix_next;
  logic [31:0]         rd_addr;
  logic [7:0]          buf_byte;
  logic                unused_ok;

  assign start_edge = wb_reg_ctr[CTR_START] & ~start_prev_q;
  assign abort      = wb_reg_ctr[CTR_ABORT];
  assign rd_ack     = (state_q == ST_READ) & p_wb_ACK_I;
  assign wr_fire    = (state_q == ST_WRITE) & ~full;
  assign last_write = wr_fire & (pack_q == LAST_C);
  assign pix_next   = pix_q + NBPACK_PIX;
  // Both counters are multiples of 4 while reading, so the sum stays word aligned.
  assign rd_addr    = {base_q, 2'b00} + 32'(pix_q) + 32'(pack_q);
  assign unused_ok  = ^{wb_reg_ctr[31:2], wb_reg_data[1:0]};

  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_WE_O   = 1'b0;
  assign p_wb_SEL_O  = WB_SEL;

  video_dma_pack_buf #(
    .NBPACK (NBPACK),
    .IDX_W  (IDX_W)
  ) u_pack_buf (
    .clk     (clk),
    .wr_en   (rd_ack),
    .wr_idx  (pack_q[IDX_W-1:0]),
    .wr_data (p_wb_DAT_I),
    .rd_idx  (pack_q[IDX_W-1:0]),
    .rd_data (buf_byte)
  );

  // State and control registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      pix_q        <= '0;
      pack_q       <= '0;
      irq_cnt_q    <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      pix_q        <= pix_d;
      pack_q       <= pack_d;
      irq_cnt_q    <= irq_cnt_d;
      start_prev_q <= start_prev_d;
    end
  end

  // Next-state logic; an abort in READ waits for the outstanding ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start_edge) state_d = ST_READ;
      ST_READ:       if (p_wb_ACK_I) state_d = abort ? ST_IDLE : ST_FILL_CHECK;
      ST_FILL_CHECK: begin
        if (abort)                 state_d = ST_IDLE;
        else if (pack_q < NBPACK_C) state_d = ST_READ;
        else                       state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort)           state_d = ST_IDLE;
        else if (last_write) state_d = (pix_next == TOTAL_C) ? ST_IRQ : ST_READ;
      end
      ST_IRQ: begin
`ifdef VIDEO_DMA_READ_CONTINUOUS_EN
        if (irq_cnt_q == INT_LAST) state_d = ST_READ;
`else
        if (irq_cnt_q == INT_LAST) state_d = ST_IDLE;
`endif
      end
      default:       state_d = ST_IDLE;
    endcase
  end

  // Counter and base updates; pack_count doubles as the write and read byte index.
  always_comb begin
    base_d       = base_q;
    pix_d        = pix_q;
    pack_d       = pack_q;
    irq_cnt_d    = '0;
    start_prev_d = wb_reg_ctr[CTR_START];
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          base_d = wb_reg_data[31:2];
          pix_d  = '0;
          pack_d = '0;
        end
      end
      ST_READ:       if (rd_ack) pack_d = pack_q + PACK_W'(4);
      ST_FILL_CHECK: if (!(pack_q < NBPACK_C)) pack_d = '0;
      ST_WRITE: begin
        if (last_write) begin
          pack_d = '0;
          pix_d  = pix_next;
        end else if (wr_fire) begin
          pack_d = pack_q + PACK_W'(1);
        end
      end
      ST_IRQ: begin
        irq_cnt_d = irq_cnt_q + 4'd1;
`ifdef VIDEO_DMA_READ_CONTINUOUS_EN
        if (irq_cnt_q == INT_LAST) begin
          pix_d  = '0;
          pack_d = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; everything is zero in IDLE.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    p_wb_STB_O = (state_q == ST_READ);
    p_wb_CYC_O = (state_q == ST_READ);
    p_wb_ADR_O = (state_q == ST_READ) ? rd_addr : 32'd0;
    interrupt  = (state_q == ST_IRQ);
    w_e        = wr_fire;
    pixel_out  = (state_q == ST_WRITE) ? buf_byte : 8'd0;
  end

endmodule

// File: tb/tb_video_dma_read.sv
// Self-checking bench for video_dma_read: Wishbone memory model, FIFO with
// full stalls, and a byte/address scoreboard.
module tb_video_dma_read;
  import video_dma_pkg::*;

  localparam int PW    = 8;
  localparam int PH    = 2;
  localparam int NBP   = 8;
  localparam int INTC  = 4;
  localparam int TOTAL = PW * PH;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic        clk;
  logic        nRST;
  logic [31:0] wb_reg_data;
  logic [31:0] wb_reg_ctr;
  logic        interrupt;
  logic        busy;
  logic [31:0] p_wb_DAT_I;
  logic        p_wb_ACK_I;
  logic        p_wb_STB_O;
  logic        p_wb_CYC_O;
  logic        p_wb_LOCK_O;
  logic        p_wb_WE_O;
  logic [3:0]  p_wb_SEL_O;
  logic [31:0] p_wb_ADR_O;
  logic        full;
  logic        w_e;
  logic [7:0]  pixel_out;

  video_dma_read #(
    .P_WIDTH    (PW),
    .P_HEIGHT   (PH),
    .NBPACK     (NBP),
    .INT_CYCLES (INTC)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .wb_reg_data (wb_reg_data),
    .wb_reg_ctr  (wb_reg_ctr),
    .interrupt   (interrupt),
    .busy        (busy),
    .p_wb_DAT_I  (p_wb_DAT_I),
    .p_wb_ACK_I  (p_wb_ACK_I),
    .p_wb_STB_O  (p_wb_STB_O),
    .p_wb_CYC_O  (p_wb_CYC_O),
    .p_wb_LOCK_O (p_wb_LOCK_O),
    .p_wb_WE_O   (p_wb_WE_O),
    .p_wb_SEL_O  (p_wb_SEL_O),
    .p_wb_ADR_O  (p_wb_ADR_O),
    .full        (full),
    .w_e         (w_e),
    .pixel_out   (pixel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];

  int ack_delay = 0;
  int wait_cnt = 0;
  int writes = 0;
  int acks = 0;
  int irq_pulses = 0;
  int irq_len = 0;
  int stall_at = 0;
  int stall_left = 0;
  int stall_seen = 0;
  bit stall_pending = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory contents as seen by the engine.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8], a[7:0] + 8'h3C, ~a[7:0]};
  endfunction

  task automatic push_frame(input logic [31:0] base);
    logic [31:0] a;
    logic [31:0] d;
    for (int w = 0; w < TOTAL / 4; w++) begin
      a = base + 32'(4 * w);
      d = word_at(a);
      addr_q.push_back(a);
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end
  endtask

  task automatic clear_stats();
    writes = 0;
    acks = 0;
    irq_pulses = 0;
    stall_seen = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    wb_reg_ctr[CTR_START] = 1'b1;
    repeat (2) @(negedge clk);
    wb_reg_ctr[CTR_START] = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    bit saw;
    bit done;
    saw = 0;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      if (busy) saw = 1;
      else if (saw) done = 1;
    end
    chk("frame_done", 32'(done), 32'd1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && writes < n; i++) begin
      @(negedge clk);
      #2;
    end
    chk("reach_writes", 32'(writes >= n), 32'd1);
  endtask

  task automatic check_idle_outputs();
    chk("irq_idle", 32'(interrupt), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("stb_idle", 32'(p_wb_STB_O), 32'd0);
    chk("cyc_idle", 32'(p_wb_CYC_O), 32'd0);
    chk("we_fifo_idle", 32'(w_e), 32'd0);
    chk("adr_idle", p_wb_ADR_O, 32'd0);
    chk("pix_idle", 32'(pixel_out), 32'd0);
  endtask

  // Wishbone slave, FIFO-full driver and output monitor.
  initial begin
    p_wb_ACK_I = 1'b0;
    p_wb_DAT_I = GARBAGE;
    full = 1'b0;
    forever begin
      @(negedge clk);
      if (!nRST) begin
        p_wb_ACK_I = 1'b0;
        p_wb_DAT_I = GARBAGE;
        wait_cnt = 0;
      end else if (p_wb_ACK_I) begin
        chk("stb_drop", 32'(p_wb_STB_O), 32'd0);
        p_wb_ACK_I = 1'b0;
        p_wb_DAT_I = GARBAGE;
      end else if (p_wb_STB_O) begin
        chk("cyc", 32'(p_wb_CYC_O), 32'd1);
        if (addr_q.size() == 0) chk("adr_extra", 32'd1, 32'd0);
        else chk("adr", p_wb_ADR_O, addr_q[0]);
        if (wait_cnt >= ack_delay) begin
          p_wb_ACK_I = 1'b1;
          p_wb_DAT_I = word_at(p_wb_ADR_O);
          if (addr_q.size() > 0) void'(addr_q.pop_front());
          wait_cnt = 0;
          acks++;
        end else begin
          wait_cnt++;
        end
      end
      if (stall_left > 0) begin
        full = 1'b1;
        stall_left--;
      end else begin
        full = 1'b0;
      end
      #1;
      if (w_e) begin
        writes++;
        if (exp_q.size() == 0) chk("w_e_extra", 32'd1, 32'd0);
        else chk("pixel", 32'(pixel_out), 32'(exp_q.pop_front()));
        if (stall_pending && writes == stall_at) begin
          stall_pending = 0;
          stall_left = 5;
        end
      end
      if (full) begin
        chk("w_e_stall", 32'(w_e), 32'd0);
        stall_seen++;
      end
      if (interrupt) begin
        irq_len++;
      end else if (irq_len > 0) begin
        irq_pulses++;
        chk("irq_len", 32'(irq_len), 32'(INTC));
`ifndef VIDEO_DMA_READ_CONTINUOUS_EN
        chk("idle_after_irq", 32'(busy), 32'd0);
`endif
        irq_len = 0;
      end
    end
  end

  initial begin
    nRST = 1'b0;
    wb_reg_data = BASE;
    wb_reg_ctr = 32'd0;
    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs();
    chk("lock", 32'(p_wb_LOCK_O), 32'd0);
    chk("wb_we", 32'(p_wb_WE_O), 32'd0);
    chk("sel", 32'(p_wb_SEL_O), 32'hF);
    @(negedge clk);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

`ifdef VIDEO_DMA_READ_CONTINUOUS_EN
    // Single start, two full frames, then abort.
    clear_stats();
    ack_delay = 0;
    push_frame(BASE);
    push_frame(BASE);
    push_frame(BASE);
    pulse_start();
    for (int i = 0; i < 2000 && irq_pulses < 2; i++) begin
      @(negedge clk);
      #2;
    end
    chk("cont_irqs", 32'(irq_pulses), 32'd2);
    wb_reg_ctr[CTR_ABORT] = 1'b1;
    wait_frame(200);
    chk("cont_writes", 32'(writes), 32'(2 * TOTAL));
    chk("cont_irqs_final", 32'(irq_pulses), 32'd2);
    chk("cont_busy", 32'(busy), 32'd0);
    wb_reg_ctr[CTR_ABORT] = 1'b0;
    exp_q.delete();
    addr_q.delete();
`else
    // Plain frame, zero-wait ACK; a second start mid-frame is ignored.
    clear_stats();
    ack_delay = 0;
    push_frame(BASE);
    pulse_start();
    wait_writes(8, 500);
    pulse_start();
    wait_frame(1000);
    chk("t2_writes", 32'(writes), 32'(TOTAL));
    chk("t2_acks", 32'(acks), 32'(TOTAL / 4));
    chk("t2_irqs", 32'(irq_pulses), 32'd1);
    chk("t2_exp_left", 32'(exp_q.size()), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // FIFO full for 5 cycles in the middle of a pack.
    clear_stats();
    push_frame(BASE);
    stall_at = 3;
    stall_pending = 1;
    pulse_start();
    wait_frame(1000);
    chk("t3_stall_cycles", 32'(stall_seen), 32'd5);
    chk("t3_writes", 32'(writes), 32'(TOTAL));
    chk("t3_exp_left", 32'(exp_q.size()), 32'd0);
    chk("t3_irqs", 32'(irq_pulses), 32'd1);

    // Slow slave: ACK after 3 wait cycles, garbage on DAT_I otherwise.
    clear_stats();
    ack_delay = 3;
    push_frame(BASE);
    pulse_start();
    wait_frame(1000);
    chk("t4_writes", 32'(writes), 32'(TOTAL));
    chk("t4_exp_left", 32'(exp_q.size()), 32'd0);
    chk("t4_addr_left", 32'(addr_q.size()), 32'd0);
    chk("t4_irqs", 32'(irq_pulses), 32'd1);

    // Abort while the first read is waiting for ACK.
    clear_stats();
    ack_delay = 3;
    push_frame(BASE);
    @(negedge clk);
    wb_reg_ctr[CTR_START] = 1'b1;
    for (int i = 0; i < 50 && !p_wb_STB_O; i++) begin
      @(negedge clk);
      #2;
    end
    wb_reg_ctr[CTR_ABORT] = 1'b1;
    wait_frame(200);
    chk("t5_acks", 32'(acks), 32'd1);
    chk("t5_writes", 32'(writes), 32'd0);
    chk("t5_irqs", 32'(irq_pulses), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    wb_reg_ctr = 32'd0;
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clk);

    // Reset in the middle of WRITE, then a clean frame.
    clear_stats();
    ack_delay = 0;
    push_frame(BASE);
    pulse_start();
    wait_writes(5, 500);
    nRST = 1'b0;
    #1;
    check_idle_outputs();
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    clear_stats();
    push_frame(BASE);
    pulse_start();
    wait_frame(1000);
    chk("t6_writes", 32'(writes), 32'(TOTAL));
    chk("t6_exp_left", 32'(exp_q.size()), 32'd0);
    chk("t6_irqs", 32'(irq_pulses), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/video_dma_read.md
VIDEO_DMA_READ -- requirements
Module: video_dma_read

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter P_HEIGHT, default 480, meaning lines per frame.
REQ-003 The block SHALL have parameter NBPACK, default 16, meaning bytes per pack; legal values are multiples of 4 in the range 4..64, and P_WIDTH*P_HEIGHT SHALL be a multiple of NBPACK.
REQ-004 The block SHALL have parameter INT_CYCLES, default 4, meaning the interrupt pulse length in cycles (1..15).
REQ-005 The block SHALL have the following ports, clock and reset first (name  direction  width  meaning):
clk  in  1  clock
nRST  in  1  reset, asynchronous, active-low
wb_reg_data  in  32  frame base byte address
wb_reg_ctr  in  32  bit0 start (rising edge), bit1 abort (level)
interrupt  out  1  frame-done pulse
busy  out  1  frame in progress
p_wb_DAT_I  in  32  read data
p_wb_ACK_I  in  1  acknowledge
p_wb_STB_O, p_wb_CYC_O  out  1  strobe/cycle
p_wb_LOCK_O  out  1  constant 0
p_wb_WE_O  out  1  constant 0
p_wb_SEL_O  out  4  constant 4'hF
p_wb_ADR_O  out  32  word-aligned byte address
full  in  1  FIFO full
w_e  out  1  FIFO write enable
pixel_out  out  8  FIFO data

Function
REQ-006 The block SHALL be an FSM with states IDLE, READ, FILL_CHECK, WRITE, IRQ; all outputs SHALL come from registers or state decode, with no latches.
REQ-007 In IDLE, a 0->1 transition of wb_reg_ctr[0] (registered edge detect) SHALL latch wb_reg_data[31:2] as base, clear the pixel and pack counters, and go to READ on the next cycle.
REQ-008 READ SHALL assert STB and CYC with ADR = base + pixel_count + pack_count (bits [1:0] = 0), holding them stable until ACK; on ACK it SHALL store DAT_I[31:24], [23:16], [15:8], [7:0] into pack bytes pack_count..pack_count+3, deassert STB/CYC the next cycle, and advance pack_count by 4.
REQ-009 FILL_CHECK SHALL return to READ if pack_count < NBPACK, else clear pack_count and go to WRITE.
REQ-010 In WRITE, w_e SHALL equal !full; pixel_out SHALL be pack byte pack_count; the index SHALL advance only when w_e=1, so no byte is dropped or duplicated across full stalls.
REQ-011 After the write of byte NBPACK-1, pixel_count SHALL increase by NBPACK; if it then equals P_WIDTH*P_HEIGHT the FSM SHALL go to IRQ, otherwise to READ.
REQ-012 In IRQ, interrupt SHALL be 1 for exactly INT_CYCLES cycles, after which the FSM goes to IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 If wb_reg_ctr[1]=1 in READ, the FSM SHALL finish the pending transfer (wait for ACK), then go to IDLE with no interrupt; in FILL_CHECK or WRITE it SHALL go to IDLE next cycle; the stored pack SHALL be discarded.
REQ-015 A start edge while busy=1 SHALL be ignored.
REQ-016 pixel_count SHALL be ceil(log2(P_WIDTH*P_HEIGHT+1)) bits wide and pack_count ceil(log2(NBPACK+1)) bits wide, with no truncation.

Reset
REQ-017 While nRST=0 the block SHALL be in IDLE with all counters 0, base 0, and interrupt, busy, STB, CYC, w_e, ADR and pixel_out all 0.
REQ-018 Reset mid-frame SHALL abort immediately; the Wishbone cycle is dropped, and no write-enable or interrupt SHALL occur until a new start edge.

Configuration
REQ-019 With VIDEO_DMA_READ_CONTINUOUS_EN defined, the FSM SHALL go from IRQ back to READ, reusing the latched base and clearing the counters, and SHALL loop until abort; undefined, it SHALL return to IDLE as in REQ-012.

Structure
REQ-020 Package video_dma_pkg SHALL hold the state enum, the control bit indices (CTR_START=0, CTR_ABORT=1) and the SEL constant.
REQ-021 The pack byte store SHALL be a sub-module video_dma_pack_buf (4-byte write port, 1-byte read port, NBPACK deep).

Verification
REQ-022 P_WIDTH=8, P_HEIGHT=2, NBPACK=8, base 0x1000, zero-wait ACK, full=0 -> reads at 0x1000..0x100C, 16 w_e pulses with bytes in address/MSB-first order, then interrupt high for 4 cycles, then IDLE.
REQ-023 Same setup with full held high for 5 cycles in mid-pack -> w_e=0 during the stall; the output byte sequence is identical to REQ-022.
REQ-024 ACK delayed 3 cycles -> STB, CYC and ADR stay stable until ACK; data is captured only on the ACK cycle.
REQ-025 Abort asserted during READ with ACK pending -> ACK is accepted, then IDLE and busy=0, and interrupt never asserts.
REQ-026 With VIDEO_DMA_READ_CONTINUOUS_EN and a single start -> two consecutive frames, both from base 0x1000, with two interrupt pulses.
REQ-027 nRST pulsed mid-WRITE -> all outputs 0 within the reset cycle; a second start edge yields a complete, correct frame.
